// File: rtl/alu_mc_pkg.sv
// Shared opcode, flag-index and FSM-state definitions for the multi-cycle ALU.
package alu_mc_pkg;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_OR    = 4'd1;
    localparam logic [3:0] OP_PASSA = 4'd2;
    localparam logic [3:0] OP_PASSB = 4'd3;
    localparam logic [3:0] OP_AND   = 4'd4;
    localparam logic [3:0] OP_SUB   = 4'd5;
    localparam logic [3:0] OP_XOR   = 4'd6;
    localparam logic [3:0] OP_CMP   = 4'd7;
    localparam logic [3:0] OP_MUL   = 4'd8;
    localparam logic [3:0] OP_DIVU  = 4'd9;
    localparam logic [3:0] OP_NOT   = 4'd10;
    localparam logic [3:0] OP_NEG   = 4'd11;
    localparam logic [3:0] OP_SLL   = 4'd12;
    localparam logic [3:0] OP_SRL   = 4'd13;
    localparam logic [3:0] OP_REMU  = 4'd14;
    localparam logic [3:0] OP_SRA   = 4'd15;

    localparam int FLAG_SF = 4;
    localparam int FLAG_ZF = 3;
    localparam int FLAG_PF = 2;
    localparam int FLAG_OF = 1;
    localparam int FLAG_CF = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } state_t;

endpackage

// File: rtl/alu_mc_if.sv
// Operation/result handshake bundle for alu_mc; master drives operations, slave is the ALU.
interface alu_mc_if #(
    parameter int WIDTH = 32
);
    logic             FLUSH;
    logic             IN_VALID;
    logic             IN_READY;
    logic [3:0]       OP;
    logic             SETF;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [4:0]       FLAGS_IN;
    logic             OUT_VALID;
    logic             OUT_READY;
    logic [WIDTH-1:0] RESULT;
    logic [4:0]       FLAGS_OUT;
    logic             WEF;
    logic             BUSY;

    modport master (
        output FLUSH, IN_VALID, OP, SETF, A, B, FLAGS_IN, OUT_READY,
        input  IN_READY, OUT_VALID, RESULT, FLAGS_OUT, WEF, BUSY
    );

    modport slave (
        input  FLUSH, IN_VALID, OP, SETF, A, B, FLAGS_IN, OUT_READY,
        output IN_READY, OUT_VALID, RESULT, FLAGS_OUT, WEF, BUSY
    );
endinterface

// File: rtl/alu_mc_iter.sv
// Shared iterative engine: shift-add multiply (MUL_STEP bits/cycle) and restoring divide.
// Divider path only exists when ALU_MC_DIV_EN is defined.
module alu_mc_iter #(
    parameter int WIDTH    = 32,
    parameter int MUL_STEP = 1
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             start,
`ifdef ALU_MC_DIV_EN
    input  logic             mode,
`endif
    input  logic             step,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] res_lo,
    output logic [WIDTH-1:0] res_hi
);
    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(WIDTH / MUL_STEP - 1);

    // hi/lo hold {acc, multiplier} for multiply and {remainder, dividend/quotient} for divide
    logic [WIDTH-1:0] hi, lo, opnd;
    logic [WIDTH-1:0] hi_n, lo_n;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH:0]   sum;
`ifdef ALU_MC_DIV_EN
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(WIDTH - 1);
    logic             mode_r;
    logic [WIDTH:0]   r_sh, trial;
`endif

    always_comb begin
        hi_n = hi;
        lo_n = lo;
        sum  = '0;
`ifdef ALU_MC_DIV_EN
        r_sh  = '0;
        trial = '0;
        if (mode_r) begin
            r_sh  = {hi, lo[WIDTH-1]};
            trial = r_sh - {1'b0, opnd};
            hi_n  = trial[WIDTH] ? r_sh[WIDTH-1:0] : trial[WIDTH-1:0];
            lo_n  = {lo[WIDTH-2:0], ~trial[WIDTH]};
        end else
`endif
        begin
            for (int unsigned i = 0; i < MUL_STEP; i++) begin
                sum = {1'b0, hi_n} + (lo_n[0] ? {1'b0, opnd} : '0);
                {hi_n, lo_n} = {sum, lo_n[WIDTH-1:1]};
            end
        end
    end

`ifdef ALU_MC_DIV_EN
    assign done = mode_r ? (cnt == DIV_LAST) : (cnt == MUL_LAST);
`else
    assign done = (cnt == MUL_LAST);
`endif
    assign res_lo = lo_n;
    assign res_hi = hi_n;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            hi   <= '0;
            lo   <= '0;
            opnd <= '0;
            cnt  <= '0;
`ifdef ALU_MC_DIV_EN
            mode_r <= 1'b0;
`endif
        end else if (start) begin
            hi   <= '0;
            lo   <= a;
            opnd <= b;
            cnt  <= '0;
`ifdef ALU_MC_DIV_EN
            mode_r <= mode;
`endif
        end else if (step) begin
            hi  <= hi_n;
            lo  <= lo_n;
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle execute ALU: 16 ops, iterative MUL, optional DIVU/REMU (macro ALU_MC_DIV_EN),
// valid/ready on both sides with a registered output stage.
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MUL_STEP = 1
) (
    input  logic     CLK,
    input  logic     N_RST,
    alu_mc_if.slave  bus
);
    localparam int SHAMT_W = $clog2(WIDTH);

    state_t           state, state_n;
    logic             out_valid, wef, setf_r;
    logic [WIDTH-1:0] result;
    logic [4:0]       flags_out;
    logic             out_blocked, in_ready, accept;
    logic             load, ld_wef;
    logic [WIDTH-1:0] ld_res, op_res, eng_res;
    logic [4:0]       ld_flags, op_flags, eng_flags;
    logic             it_start, it_step, it_done;
    logic [WIDTH-1:0] it_lo, it_hi;
    logic [WIDTH:0]   add_x, sub_x, sll_x, srl_x, sra_x;
    logic [SHAMT_W-1:0] shamt;
`ifdef ALU_MC_DIV_EN
    logic             it_mode, rem_r;
`endif

    function automatic logic [4:0] flags_of(input logic [WIDTH-1:0] r, input logic ovf,
                                            input logic cry);
        logic [4:0] f;
        f          = '0;
        f[FLAG_SF] = r[WIDTH-1];
        f[FLAG_ZF] = (r == '0);
        f[FLAG_PF] = ~^r[7:0];
        f[FLAG_OF] = ovf;
        f[FLAG_CF] = cry;
        return f;
    endfunction

    assign out_blocked = out_valid & ~bus.OUT_READY;
    assign in_ready    = (state == ST_IDLE) & ~out_blocked & ~bus.FLUSH;
    assign accept      = bus.IN_VALID & in_ready;

    assign shamt = bus.B[SHAMT_W-1:0];
    assign add_x = {1'b0, bus.A} + {1'b0, bus.B};
    assign sub_x = {1'b0, bus.A} - {1'b0, bus.B};
    // One extra bit beside the operand catches the last bit shifted out
    assign sll_x = {1'b0, bus.A} << shamt;
    assign srl_x = {bus.A, 1'b0} >> shamt;
    assign sra_x = $signed({bus.A, 1'b0}) >>> shamt;

    always_comb begin
        op_res   = '0;
        op_flags = bus.FLAGS_IN;
        case (bus.OP)
            OP_ADD: begin
                op_res   = add_x[WIDTH-1:0];
                op_flags = flags_of(op_res, (bus.A[WIDTH-1] == bus.B[WIDTH-1]) &
                                    (op_res[WIDTH-1] != bus.A[WIDTH-1]), add_x[WIDTH]);
            end
            OP_SUB, OP_CMP: begin
                op_res   = (bus.OP == OP_CMP) ? bus.A : sub_x[WIDTH-1:0];
                op_flags = flags_of(sub_x[WIDTH-1:0], (bus.A[WIDTH-1] != bus.B[WIDTH-1]) &
                                    (sub_x[WIDTH-1] != bus.A[WIDTH-1]), sub_x[WIDTH]);
            end
            OP_OR:    begin op_res = bus.A | bus.B; op_flags = flags_of(op_res, 1'b0, 1'b0); end
            OP_AND:   begin op_res = bus.A & bus.B; op_flags = flags_of(op_res, 1'b0, 1'b0); end
            OP_XOR:   begin op_res = bus.A ^ bus.B; op_flags = flags_of(op_res, 1'b0, 1'b0); end
            OP_PASSA: op_res = bus.A;
            OP_PASSB: op_res = bus.B;
            OP_NOT:   op_res = ~bus.B;
            OP_NEG: begin
                op_res   = -bus.B;
                op_flags = flags_of(op_res, 1'b0, bus.B != '0);
            end
            OP_MUL:   op_res = '0;
            OP_DIVU, OP_REMU: begin
`ifdef ALU_MC_DIV_EN
                // Only loaded directly on divide-by-zero; otherwise the DIV state runs
                op_res   = (bus.OP == OP_DIVU) ? '1 : bus.A;
                op_flags = flags_of(op_res, 1'b0, 1'b1);
`else
                op_res   = '0;
                op_flags = flags_of('0, 1'b1, 1'b0);
`endif
            end
            OP_SLL: begin
                op_res = bus.A;
                if (shamt != '0) begin
                    op_res   = sll_x[WIDTH-1:0];
                    op_flags = flags_of(op_res, op_res[WIDTH-1] ^ sll_x[WIDTH], sll_x[WIDTH]);
                end
            end
            OP_SRL: begin
                op_res = bus.A;
                if (shamt != '0) begin
                    op_res   = srl_x[WIDTH:1];
                    op_flags = flags_of(op_res, bus.A[WIDTH-1], srl_x[0]);
                end
            end
            OP_SRA: begin
                op_res = bus.A;
                if (shamt != '0) begin
                    op_res   = sra_x[WIDTH:1];
                    op_flags = flags_of(op_res, 1'b0, sra_x[0]);
                end
            end
        endcase
    end

    always_comb begin
        eng_res   = it_lo;
        eng_flags = flags_of(it_lo, it_hi != '0, it_hi != '0);
`ifdef ALU_MC_DIV_EN
        if (state == ST_DIV) begin
            eng_res   = rem_r ? it_hi : it_lo;
            eng_flags = flags_of(eng_res, 1'b0, 1'b0);
        end
`endif
    end

    always_comb begin
        state_n  = state;
        load     = 1'b0;
        ld_res   = op_res;
        ld_flags = op_flags;
        ld_wef   = (state == ST_IDLE) ? bus.SETF : setf_r;
        it_start = 1'b0;
        it_step  = 1'b0;
`ifdef ALU_MC_DIV_EN
        it_mode  = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (bus.OP == OP_MUL) begin
                        it_start = 1'b1;
                        state_n  = ST_MUL;
                    end
`ifdef ALU_MC_DIV_EN
                    else if ((bus.OP == OP_DIVU || bus.OP == OP_REMU) && bus.B != '0) begin
                        it_start = 1'b1;
                        it_mode  = 1'b1;
                        state_n  = ST_DIV;
                    end
`endif
                    else begin
                        load = 1'b1;
                    end
                end
            end
            default: begin
                // Last iteration stalls in place until the output register is free
                it_step = ~(it_done & out_blocked);
                if (it_done && !out_blocked) begin
                    load     = 1'b1;
                    ld_res   = eng_res;
                    ld_flags = eng_flags;
                    state_n  = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!N_RST) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            flags_out <= '0;
            wef       <= 1'b0;
            setf_r    <= 1'b0;
`ifdef ALU_MC_DIV_EN
            rem_r     <= 1'b0;
`endif
        end else if (bus.FLUSH) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
        end else begin
            state <= state_n;
            if (accept) begin
                setf_r <= bus.SETF;
`ifdef ALU_MC_DIV_EN
                rem_r  <= (bus.OP == OP_REMU);
`endif
            end
            if (load) begin
                out_valid <= 1'b1;
                result    <= ld_res;
                flags_out <= ld_flags;
                wef       <= ld_wef;
            end else if (bus.OUT_READY) begin
                out_valid <= 1'b0;
            end
        end
    end

    alu_mc_iter #(
        .WIDTH    (WIDTH),
        .MUL_STEP (MUL_STEP)
    ) u_iter (
        .clk    (CLK),
        .n_rst  (N_RST),
        .start  (it_start),
`ifdef ALU_MC_DIV_EN
        .mode   (it_mode),
`endif
        .step   (it_step),
        .a      (bus.A),
        .b      (bus.B),
        .done   (it_done),
        .res_lo (it_lo),
        .res_hi (it_hi)
    );

    assign bus.IN_READY  = in_ready;
    assign bus.OUT_VALID = out_valid;
    assign bus.RESULT    = result;
    assign bus.FLAGS_OUT = flags_out;
    assign bus.WEF       = wef;
    assign bus.BUSY      = (state != ST_IDLE);

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised multi-cycle successor to the single-cycle execute ALU.
- Adds iterative multiply and unsigned divide/remainder alongside the existing 16-op set. Width is generic, and both input and output sides use valid/ready handshakes.
- Sits between decode/register-read and writeback/LSU. A registered output stage absorbs writeback stalls.
- Flag vector keeps the codebase order {SF,ZF,PF,OF,CF}.

Parameters:
- WIDTH, 32: datapath width. Must be ≥ 8 and a power of 2.
- MUL_STEP, 1: multiplier bits retired per cycle. Must divide WIDTH.
- SHAMT_W, $clog2(WIDTH): shift-amount width. Localparam, not overridable.

Ports:
- CLK in 1: clock.
- N_RST in 1: synchronous active-low reset.
- FLUSH in 1: abort the in-flight operation and discard the pending output.
- IN_VALID in 1: operation offered.
- IN_READY out 1: operation accepted when IN_VALID & IN_READY.
- OP in 4: opcode.
- SETF in 1: write flags for this operation.
- A in WIDTH: operand A.
- B in WIDTH: operand B; low SHAMT_W bits are the shift amount.
- FLAGS_IN in 5: current architectural flags.
- OUT_VALID out 1: result held.
- OUT_READY in 1: consumer takes the result.
- RESULT out WIDTH: result.
- FLAGS_OUT out 5: new flags.
- WEF out 1: flag write enable (SETF captured at accept).
- BUSY out 1: multi-cycle operation in progress.

Behaviour:
- Reset: on CLK edge with N_RST=0, state=IDLE. OUT_VALID=0, RESULT=0, FLAGS_OUT=0, WEF=0, BUSY=0. Any in-flight operation is dropped. Reset overrides FLUSH and IN_VALID.
- Opcodes:
  - 0 ADD A+B
  - 1 OR
  - 2 PASSA
  - 3 PASSB
  - 4 AND
  - 5 SUB A−B
  - 6 XOR
  - 7 CMP: A−B flags, RESULT=A
  - 8 MUL: low WIDTH bits, unsigned
  - 9 DIVU quotient
  - 10 NOT B
  - 11 NEG −B
  - 12 SLL A by B
  - 13 SRL
  - 14 REMU
  - 15 SRA
- Flags, common to all operations: SF=R[W−1]; ZF=(R==0); PF=~^R[7:0].
- Flags, per operation:
  - ADD: CF=carry-out; OF=(A[W−1]==B[W−1])&(R[W−1]!=A[W−1]).
  - SUB/CMP: CF=borrow (A<B unsigned); OF=(A[W−1]!=B[W−1])&(R[W−1]!=A[W−1]).
  - Logic ops: OF=CF=0.
  - NEG: CF=(B!=0), OF=0.
  - MUL: CF=OF=(high WIDTH bits of product != 0).
  - DIVU/REMU: OF=0; CF=1 only on divide-by-zero.
  - Shifts: CF=last bit shifted out. SLL OF=R[W−1]^CF; SRL OF=A[W−1]; SRA OF=0.
  - Shift by 0: RESULT=A and FLAGS_OUT=FLAGS_IN.
  - PASSA/PASSB/NOT: FLAGS_OUT=FLAGS_IN.
- States: IDLE, MUL, DIV.
- IN_READY = (state==IDLE) & (~OUT_VALID | OUT_READY) & ~FLUSH.
- Single-cycle ops: on accept, the output register loads next edge, so OUT_VALID rises 1 cycle after accept.
- OP 8, on accept:
  - Latch operands and go to MUL; BUSY=1.
  - Shift-add MUL_STEP bits per cycle over WIDTH/MUL_STEP cycles.
  - Then load the output register and return to IDLE.
  - OUT_VALID rises WIDTH/MUL_STEP+1 cycles after accept.
- OP 9/14, on accept:
  - Go to DIV: restoring division, 1 bit per cycle, WIDTH cycles.
  - OUT_VALID rises WIDTH+1 cycles after accept.
  - Divide-by-zero skips iteration: quotient = all-ones, remainder = A, CF=1, OUT_VALID 1 cycle after accept.
- Output hold: RESULT/FLAGS_OUT/WEF stay stable while OUT_VALID & ~OUT_READY.
- Simultaneous events:
  - OUT_READY and a new accept in the same cycle: old result retires, new one loads; no bubble for single-cycle ops.
  - Multi-cycle completion while OUT_VALID & ~OUT_READY: state holds in its last iteration (BUSY stays 1) until the register frees.
- FLUSH (any state): state→IDLE, BUSY=0, OUT_VALID=0 next edge. An input offered in the same cycle is not accepted.

Optional Feature:
- Macro ALU_MC_DIV_EN.
- Defined: DIV state and divider datapath are present, as above.
- Undefined: no divider logic. OP 9/14 complete in 1 cycle with RESULT=0, FLAGS_OUT={0,1,1,1,0} (OF flags unimplemented), WEF=SETF.

Decomposition:
- Package alu_mc_pkg holds:
  - opcode localparams (OP_ADD..OP_SRA);
  - flag bit indices (FLAG_SF=4..FLAG_CF=0);
  - the state enum (ST_IDLE, ST_MUL, ST_DIV).
- One sub-module alu_mc_iter: shared iterative multiply/divide engine with start/done, selected by a mode bit. Combinational ops and flag logic stay in alu_mc.

Test Plan:
- ADD 0x7FFFFFFF+0x00000001, SETF=1 → next cycle RESULT=0x80000000, FLAGS_OUT=SF1 ZF0 PF1 OF1 CF0, WEF=1.
- MUL 0x00010000×0x00010001, MUL_STEP=1 → BUSY 32 cycles; OUT_VALID at accept+33; RESULT=0x00010000, CF=OF=1. Repeat with MUL_STEP=4 → OUT_VALID at accept+9.
- Divider, with ALU_MC_DIV_EN:
  - DIVU 100/7 → 0x0000000E.
  - REMU 100/7 → 0x00000002.
  - DIVU 0x1234/0 → 0xFFFFFFFF, CF=1, latency 1.
  - Without the macro → RESULT=0, OF=1.
- Backpressure: hold OUT_READY=0 for 3 cycles after an ADD result → RESULT stable, IN_READY=0. Raise OUT_READY with IN_VALID=1 (XOR 0xF0F0F0F0^0xFFFFFFFF) → accepted that cycle; next cycle RESULT=0x0F0F0F0F.
- FLUSH in cycle 10 of a MUL → OUT_VALID never rises, BUSY=0 and IN_READY=1 next cycle. N_RST=0 mid-DIV → all outputs 0 next edge.
- SRA 0x80000000 by 4 → 0xF8000000, CF=0. SLL 0xC0000000 by 1 → 0x80000000, CF=1, OF=0. Shift by 0 with FLAGS_IN=5'b10101 → FLAGS_OUT=5'b10101.
